// File: rtl/mc_ctrl_alu_if.sv
// Bus between the mc_ctrl_alu control core and its datapath.
// The datapath side (master) drives the instruction register, the PC and the
// muxed ALU operands. The control core (slave) returns the ALU result, PC+4
// and every mux select and write enable.
interface mc_ctrl_alu_if;
  logic [31:0] instr;
  logic [31:0] pc_q;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] pc_plus4;
  logic        pc_write_en;
  logic        iord;
  logic        ir_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  pc_src;
  logic [4:0]  alu_control;
  logic        mem_to_reg;
  logic        mem_write;
  logic        reg_dst;
  logic        reg_write;
  logic        jump;
  logic        jump_reg;
  logic        branch;

  modport master (
    output instr, pc_q, src_a, src_b,
    input  alu_result, zero, pc_plus4, pc_write_en, iord, ir_write,
           alu_src_a, alu_src_b, pc_src, alu_control, mem_to_reg,
           mem_write, reg_dst, reg_write, jump, jump_reg, branch
  );

  modport slave (
    input  instr, pc_q, src_a, src_b,
    output alu_result, zero, pc_plus4, pc_write_en, iord, ir_write,
           alu_src_a, alu_src_b, pc_src, alu_control, mem_to_reg,
           mem_write, reg_dst, reg_write, jump, jump_reg, branch
  );
endinterface

// File: rtl/mc_ctrl_alu.sv
// Multicycle MIPS-subset control core: control FSM, 32-bit ALU and PC+4.
// Optional feature macro: EXT_ALU_EN adds XOR (funct 0x26) and NOR
// (funct 0x27) R-type operations. Without it those functs are treated as
// unknown and the ALU codes 00011 / 01100 yield 0.
module mc_ctrl_alu #(
  parameter int WIDTH = 32
) (
  input logic          clock,
  input logic          reset_n,
  mc_ctrl_alu_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPE_EX, S_RTYPE_WB, S_ADDI_EX, S_ADDI_WB,
    S_BEQ, S_JUMP, S_JR, S_JAL
  } state_e;

  typedef enum logic [4:0] {
    ALU_AND   = 5'b00000,
    ALU_OR    = 5'b00001,
    ALU_ADD   = 5'b00010,
    ALU_XOR   = 5'b00011,
    ALU_SUB   = 5'b00110,
    ALU_SLT   = 5'b00111,
    ALU_PASSA = 5'b01000,
    ALU_NOR   = 5'b01100
  } alu_op_e;

  // Complete control word for one state; pc_write is the unconditional part
  // of the PC enable, branch adds the beq condition on top of it.
  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    alu_op_e    alu_control;
    logic       mem_to_reg;
    logic       mem_write;
    logic       reg_dst;
    logic       reg_write;
    logic       jump;
    logic       jump_reg;
    logic       branch;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  wire logic [5:0] opcode = bus.instr[31:26];
  wire logic [5:0] funct  = bus.instr[5:0];

  // Register and immediate fields are consumed by the datapath, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.instr[25:6];

  // R-type functs that run through RTYPE_EX/RTYPE_WB.
  function automatic logic funct_is_alu(input logic [5:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
`ifdef EXT_ALU_EN
      FN_XOR, FN_NOR:                        return 1'b1;
`endif
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic alu_op_e funct_op(input logic [5:0] f);
    case (f)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
`ifdef EXT_ALU_EN
      FN_XOR:  return ALU_XOR;
      FN_NOR:  return ALU_NOR;
`endif
      default: return ALU_AND;
    endcase
  endfunction

  // Moore control word for a state; only RTYPE_EX also looks at funct.
  function automatic ctrl_t ctrl_for(input state_e s, input logic [5:0] f);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write    = 1'b1;
        c.alu_src_b   = 2'b01;
        c.alu_control = ALU_ADD;
        c.pc_write    = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b   = 2'b11;
        c.alu_control = ALU_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = 2'b10;
        c.alu_control = ALU_ADD;
      end
      S_MEMRD:    c.iord = 1'b1;
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_RTYPE_EX: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = funct_op(f);
      end
      S_RTYPE_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_ADDI_WB:  c.reg_write = 1'b1;
      S_BEQ: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = ALU_SUB;
        c.branch      = 1'b1;
        c.pc_src      = 2'b01;
      end
      S_JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      S_JR: begin
        c.pc_src   = 2'b10;
        c.jump_reg = 1'b1;
        c.pc_write = 1'b1;
      end
      S_JAL: begin
        c.alu_control = ALU_PASSA;
        c.reg_write   = 1'b1;
        c.jump        = 1'b1;
        c.pc_src      = 2'b10;
        c.pc_write    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  // Next-state selection and the control word that goes with it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          OP_RTYPE: begin
            if (funct == FN_JR)         state_d = S_JR;
            else if (funct_is_alu(funct)) state_d = S_RTYPE_EX;
            else                        state_d = S_FETCH;
          end
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:    state_d = S_MEMWB;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      default:    state_d = S_FETCH;
    endcase
    ctrl_d = ctrl_for(state_d, funct);
  end

  // State and registered control word; reset parks both in FETCH.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_for(S_FETCH, 6'h00);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // ALU: wrapping add/sub, signed slt, pass-through of A; other codes give 0.
  logic [WIDTH-1:0] alu_y;
  always_comb begin
    alu_y = '0;
    case (ctrl_q.alu_control)
      ALU_AND:   alu_y = bus.src_a & bus.src_b;
      ALU_OR:    alu_y = bus.src_a | bus.src_b;
      ALU_ADD:   alu_y = bus.src_a + bus.src_b;
      ALU_SUB:   alu_y = bus.src_a - bus.src_b;
      ALU_SLT:   alu_y = {{(WIDTH-1){1'b0}},
                          ($signed(bus.src_a) < $signed(bus.src_b))};
      ALU_PASSA: alu_y = bus.src_a;
`ifdef EXT_ALU_EN
      ALU_XOR:   alu_y = bus.src_a ^ bus.src_b;
      ALU_NOR:   alu_y = ~(bus.src_a | bus.src_b);
`endif
      default:   alu_y = '0;
    endcase
  end

  assign bus.alu_result = alu_y;
  assign bus.zero       = (alu_y == '0);
  assign bus.pc_plus4   = bus.pc_q + 32'd4;

  // NOTE: the write enables are gated by reset_n directly so they drop the
  // moment reset asserts, not at the next clock edge.
  assign bus.pc_write_en = reset_n & (ctrl_q.pc_write | (ctrl_q.branch & bus.zero));
  assign bus.ir_write    = reset_n & ctrl_q.ir_write;
  assign bus.mem_write   = reset_n & ctrl_q.mem_write;
  assign bus.reg_write   = reset_n & ctrl_q.reg_write;

  assign bus.iord        = ctrl_q.iord;
  assign bus.alu_src_a   = ctrl_q.alu_src_a;
  assign bus.alu_src_b   = ctrl_q.alu_src_b;
  assign bus.pc_src      = ctrl_q.pc_src;
  assign bus.alu_control = ctrl_q.alu_control;
  assign bus.mem_to_reg  = ctrl_q.mem_to_reg;
  assign bus.reg_dst     = ctrl_q.reg_dst;
  assign bus.jump        = ctrl_q.jump;
  assign bus.jump_reg    = ctrl_q.jump_reg;
  assign bus.branch      = ctrl_q.branch;

endmodule

// File: tb/tb_mc_ctrl_alu.sv
// Self-checking bench for mc_ctrl_alu: directed instructions from the test
// plan followed by random instructions with random operands, all compared
// against a per-instruction cycle table and an arithmetic ALU model.
module tb_mc_ctrl_alu;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  mc_ctrl_alu_if bus();

  mc_ctrl_alu #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       pcw, iord, irw, asa;
    logic [1:0] asb, psrc;
    logic [4:0] alu;
    logic       m2r, mw, rdst, rw, jmp, jr, br;
  } ctl_t;

  typedef enum {K_LW, K_SW, K_R, K_ADDI, K_BEQ, K_J, K_JR, K_JAL, K_BAD} kind_e;

  function automatic ctl_t observed();
    ctl_t c;
    c.pcw  = bus.pc_write_en;  c.iord = bus.iord;      c.irw = bus.ir_write;
    c.asa  = bus.alu_src_a;    c.asb  = bus.alu_src_b; c.psrc = bus.pc_src;
    c.alu  = bus.alu_control;  c.m2r  = bus.mem_to_reg; c.mw  = bus.mem_write;
    c.rdst = bus.reg_dst;      c.rw   = bus.reg_write; c.jmp = bus.jump;
    c.jr   = bus.jump_reg;     c.br   = bus.branch;
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Arithmetic meaning of each ALU code.
  function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0:  return a & b;
      5'd1:  return a | b;
      5'd2:  return a + b;
      5'd6:  return a - b;
      5'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd8:  return a;
`ifdef EXT_ALU_EN
      5'd3:  return a ^ b;
      5'd12: return ~(a | b);
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Instruction word -> instruction kind and, for R-type, its ALU code.
  function automatic kind_e classify(input logic [31:0] ins, output logic [4:0] rop);
    rop = 5'd0;
    case (ins[31:26])
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h08: return K_ADDI;
      6'h02: return K_J;
      6'h03: return K_JAL;
      6'h00: begin
        case (ins[5:0])
          6'h20: begin rop = 5'd2; return K_R; end
          6'h22: begin rop = 5'd6; return K_R; end
          6'h24: begin rop = 5'd0; return K_R; end
          6'h25: begin rop = 5'd1; return K_R; end
          6'h2A: begin rop = 5'd7; return K_R; end
          6'h08: return K_JR;
`ifdef EXT_ALU_EN
          6'h26: begin rop = 5'd3;  return K_R; end
          6'h27: begin rop = 5'd12; return K_R; end
`endif
          default: return K_BAD;
        endcase
      end
      default: return K_BAD;
    endcase
  endfunction

  function automatic int instr_len(input kind_e k);
    case (k)
      K_LW:              return 5;
      K_SW, K_R, K_ADDI: return 4;
      K_BAD:             return 2;
      default:           return 3;
    endcase
  endfunction

  // Expected control for cycle k of an instruction (k=0 is fetch).
  function automatic ctl_t expect_ctl(input kind_e kd, input logic [4:0] rop, input int k, input logic eq);
    ctl_t c;
    c = '0;
    if (k == 0) begin
      c.irw = 1'b1; c.asb = 2'b01; c.alu = 5'd2; c.pcw = 1'b1;
    end else if (k == 1) begin
      c.asb = 2'b11; c.alu = 5'd2;
    end else begin
      case (kd)
        K_LW, K_SW: begin
          if (k == 2) begin c.asa = 1'b1; c.asb = 2'b10; c.alu = 5'd2; end
          else if (kd == K_LW && k == 3) c.iord = 1'b1;
          else if (kd == K_LW) begin c.rw = 1'b1; c.m2r = 1'b1; end
          else begin c.iord = 1'b1; c.mw = 1'b1; end
        end
        K_R: begin
          if (k == 2) begin c.asa = 1'b1; c.alu = rop; end
          else begin c.rw = 1'b1; c.rdst = 1'b1; end
        end
        K_ADDI: begin
          if (k == 2) begin c.asa = 1'b1; c.asb = 2'b10; c.alu = 5'd2; end
          else c.rw = 1'b1;
        end
        K_BEQ: begin
          c.asa = 1'b1; c.alu = 5'd6; c.br = 1'b1; c.psrc = 2'b01; c.pcw = eq;
        end
        K_J:   begin c.psrc = 2'b10; c.pcw = 1'b1; end
        K_JR:  begin c.psrc = 2'b10; c.pcw = 1'b1; c.jr = 1'b1; end
        K_JAL: begin
          c.alu = 5'd8; c.rw = 1'b1; c.jmp = 1'b1; c.psrc = 2'b10; c.pcw = 1'b1;
        end
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  // Run one instruction (or its first stop_after cycles) from fetch,
  // checking control, ALU result, zero and PC+4 in every cycle.
  task automatic run_instr(input logic [31:0] ins, input int stop_after,
                           input logic fixed, input logic [31:0] fa, input logic [31:0] fb);
    kind_e      kd;
    logic [4:0] rop;
    int         n;
    kd = classify(ins, rop);
    n  = instr_len(kd);
    if (stop_after < n) n = stop_after;
    for (int k = 0; k < n; k++) begin
      ctl_t        e;
      logic [31:0] a, b, y, pc;
      pc = $urandom;
      a  = fixed ? fa : $urandom;
      b  = fixed ? fb : (($urandom_range(1, 0) == 1) ? a : $urandom);
      bus.instr = ins;
      bus.pc_q  = pc;
      bus.src_a = a;
      bus.src_b = b;
      e = expect_ctl(kd, rop, k, a == b);
      y = alu_ref(e.alu, a, b);
      @(negedge clock);
      check($sformatf("ctl_%s_c%0d_%h", kd.name(), k, ins), observed(), e);
      check($sformatf("alu_%s_c%0d", kd.name(), k), bus.alu_result, y);
      check($sformatf("zero_%s_c%0d", kd.name(), k), {31'd0, bus.zero}, {31'd0, y == 32'd0});
      check("pc_plus4", bus.pc_plus4, pc + 32'd4);
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(15, 0))
      0:  return {6'h23, r[25:0]};
      1:  return {6'h2B, r[25:0]};
      2:  return {6'h00, r[25:6], 6'h20};
      3:  return {6'h00, r[25:6], 6'h22};
      4:  return {6'h00, r[25:6], 6'h24};
      5:  return {6'h00, r[25:6], 6'h25};
      6:  return {6'h00, r[25:6], 6'h2A};
      7:  return {6'h08, r[25:0]};
      8:  return {6'h04, r[25:0]};
      9:  return {6'h02, r[25:0]};
      10: return {6'h03, r[25:0]};
      11: return {6'h00, r[25:6], 6'h08};
      12: return {6'h00, r[25:6], 6'h26};
      13: return {6'h00, r[25:6], 6'h27};
      14: return {6'h3F, r[25:0]};
      default: return {6'h00, r[25:6], 6'h3F};
    endcase
  endfunction

  initial begin
    ctl_t rst_exp;
    bus.instr = 32'd0;
    bus.pc_q  = 32'h100;
    bus.src_a = 32'd0;
    bus.src_b = 32'd0;

    // Held in reset: write enables low, other outputs at fetch values.
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst_exp = '0; rst_exp.asb = 2'b01; rst_exp.alu = 5'd2;
    check("reset_ctl", observed(), rst_exp);
    check("reset_pc_plus4", bus.pc_plus4, 32'h104);

    // Release away from the edge: fetch enables appear before any edge.
    @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    check("release_ir_write", {31'd0, bus.ir_write}, 32'd1);
    check("release_pc_write_en", {31'd0, bus.pc_write_en}, 32'd1);
    check("release_alu_src_b", {30'd0, bus.alu_src_b}, 32'd1);

    // Fetch cycle add: 0xFFFFFFFF + 1 wraps to 0.
    run_instr(32'h8C220004, 99, 1'b1, 32'hFFFFFFFF, 32'd1);
    // beq taken / not taken, and 5 - 7.
    run_instr(32'h10220003, 99, 1'b1, 32'd7, 32'd7);
    run_instr(32'h10220003, 99, 1'b1, 32'd7, 32'd8);
    run_instr(32'h10220003, 99, 1'b1, 32'd5, 32'd7);
    // Signed slt: 0x80000000 < 1.
    run_instr(32'h0022182A, 99, 1'b1, 32'h80000000, 32'd1);
    // jal, jr, and the optional xor funct.
    run_instr(32'h0C000040, 99, 1'b0, 32'd0, 32'd0);
    run_instr(32'h03E00008, 99, 1'b0, 32'd0, 32'd0);
    run_instr(32'h00221826, 99, 1'b1, 32'h0000F0F0, 32'h00000FF0);
    run_instr(32'h2022000C, 99, 1'b0, 32'd0, 32'd0);

    // Reset in the middle of a lw abandons it; execution restarts at fetch.
    run_instr(32'h8C220004, 3, 1'b0, 32'd0, 32'd0);
    reset_n = 1'b0;
    #1;
    check("midreset_ctl", observed(), rst_exp);
    @(posedge clock);
    #1 reset_n = 1'b1;
    run_instr(32'hAC220008, 99, 1'b0, 32'd0, 32'd0);

    // Random instruction stream.
    for (int i = 0; i < 250; i++) begin
      run_instr(rand_instr(), 99, 1'b0, 32'd0, 32'd0);
    end
    // Trailing fetch confirms the last instruction returned to fetch.
    run_instr(32'h00000020, 1, 1'b0, 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
